// File: rtl/fc_pkg.sv
// Shared types and constants for the Z80-to-68000 banked window arbiter.
package fc_pkg;

    localparam int         BANK_W        = 9;
    localparam logic [7:0] BANK_REG_PAGE = 8'h60;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        END    = 3'd4,
        REL    = 3'd5
    } fsm_state_t;

endpackage

// File: rtl/z80_bank_reg.sv
// Serial 9-bit bank register (shifted in one bit per write, LSB-first order)
// and the 68000 word address builder for the 32 KB window.
module z80_bank_reg
    import fc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_en,
    input  logic        shift_bit,
    input  logic [13:0] win_addr,
    output logic [22:0] win_va
);

    logic [BANK_W-1:0] bank;

    // Newest bit enters at the top, so nine writes leave the first one in bank[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
        end else if (shift_en) begin
            bank <= {shift_bit, bank[BANK_W-1:1]};
        end
    end

    assign win_va = {bank, win_addr};

endmodule

// File: rtl/z80_bank_arbiter.sv
// Sequences Z80 window accesses onto the 68000 bus via BR/BG/BGACK and one byte cycle.
// Optional DTACK timeout is built when Z80_BANK_TIMEOUT_EN is defined.
module z80_bank_arbiter
    import fc_pkg::*;
#(
`ifdef Z80_BANK_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 128,
`endif
    parameter int SETUP_CYC = 1
) (
    input  logic        MCLK,
    input  logic        RESET_n,
    input  logic        z_mreq,
    input  logic        z_rd,
    input  logic        z_wr,
    input  logic [15:0] z_addr,
    input  logic [7:0]  z_wdata,
    output logic [7:0]  z_rdata,
    output logic        z_wait,
    output logic        m_br,
    input  logic        m_bg,
    input  logic        m_as_in,
    output logic        m_bgack,
    input  logic        m_dtack,
    output logic [22:0] va,
    output logic        va_oe,
    output logic        m_as,
    output logic        m_uds,
    output logic        m_lds,
    output logic        m_rw,
    input  logic [15:0] vd_in,
    output logic [15:0] vd_out,
    output logic        vd_oe,
    output logic [2:0]  dbg_state
);

    localparam logic [1:0] SETUP_LAST = 2'(SETUP_CYC - 1);

    fsm_state_t  state, state_d;
    logic        z_mreq_q;
    logic        mreq_rise, bank_we, win_start;
    logic        grant, strobe_go, bus_done, tmo_hit;
    logic        acc_rd, acc_lane;
    logic [1:0]  setup_cnt;
    logic [22:0] win_va;

    assign mreq_rise = z_mreq & ~z_mreq_q;
    assign bank_we   = mreq_rise & z_wr & (z_addr[15:8] == BANK_REG_PAGE) & (state == IDLE);
    assign win_start = mreq_rise & z_addr[15] & (z_rd | z_wr) & (state == IDLE);
    assign dbg_state = state;

    z80_bank_reg u_bank_reg (
        .clk       (MCLK),
        .rst_n     (RESET_n),
        .shift_en  (bank_we),
        .shift_bit (z_wdata[0]),
        .win_addr  (z_addr[14:1]),
        .win_va    (win_va)
    );

`ifdef Z80_BANK_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tmo_cnt;

    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            tmo_cnt <= '0;
        end else if (state == STROBE && state_d == STROBE) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        grant     = 1'b0;
        strobe_go = 1'b0;
        bus_done  = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE:   if (win_start) state_d = REQ;
            // The grant only counts once our request is actually on the bus.
            REQ:    if (m_br & m_bg & ~m_as_in) begin
                        grant   = 1'b1;
                        state_d = SETUP;
                    end
            SETUP:  if (setup_cnt == SETUP_LAST) begin
                        strobe_go = 1'b1;
                        state_d   = STROBE;
                    end
            STROBE: begin
                        if (m_dtack) begin
                            bus_done = 1'b1;
                            state_d  = END;
                        end
`ifdef Z80_BANK_TIMEOUT_EN
                        else if (tmo_cnt == TMO_LAST) begin
                            tmo_hit  = 1'b1;
                            bus_done = 1'b1;
                            state_d  = END;
                        end
`endif
                    end
            END:    state_d = REL;
            REL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            z_mreq_q  <= 1'b0;
            z_rdata   <= '0;
            z_wait    <= 1'b0;
            m_br      <= 1'b0;
            m_bgack   <= 1'b0;
            va        <= '0;
            va_oe     <= 1'b0;
            m_as      <= 1'b0;
            m_uds     <= 1'b0;
            m_lds     <= 1'b0;
            m_rw      <= 1'b1;
            vd_out    <= '0;
            vd_oe     <= 1'b0;
            acc_rd    <= 1'b0;
            acc_lane  <= 1'b0;
            setup_cnt <= '0;
        end else begin
            z_mreq_q <= z_mreq;
            // BR rises one cycle into REQ and drops one cycle after BGACK.
            m_br     <= (state == REQ);
            if (win_start) begin
                z_wait   <= 1'b1;
                acc_rd   <= z_rd;
                acc_lane <= z_addr[0];
                va       <= win_va;
                vd_out   <= {z_wdata, z_wdata};
            end
            if (grant) begin
                m_bgack   <= 1'b1;
                va_oe     <= 1'b1;
                m_rw      <= acc_rd;
                vd_oe     <= ~acc_rd;
                setup_cnt <= '0;
            end
            if (state == SETUP) begin
                setup_cnt <= setup_cnt + 2'd1;
            end
            if (strobe_go) begin
                m_as  <= 1'b1;
                m_uds <= ~acc_lane;
                m_lds <= acc_lane;
            end
            if (bus_done) begin
                m_as  <= 1'b0;
                m_uds <= 1'b0;
                m_lds <= 1'b0;
                if (acc_rd) begin
                    z_rdata <= tmo_hit ? 8'hFF : (acc_lane ? vd_in[7:0] : vd_in[15:8]);
                end
            end
            if (state == REL) begin
                m_bgack <= 1'b0;
                va_oe   <= 1'b0;
                vd_oe   <= 1'b0;
                m_rw    <= 1'b1;
                z_wait  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/z80_bank_arbiter.md
Name: z80_bank_arbiter

Overview:
- Sequences Z80 accesses to the 68000 bus through the 32 KB banked window at Z80 0x8000-0xFFFF.
- Holds the bank register written serially at Z80 0x6000xx.
- Runs a full bus-request handshake with the 68000 (BR/BG/BGACK), then a single byte cycle (AS, UDS/LDS, RW, DTACK). The Z80 is stalled with WAIT throughout.
- Sits inside the system gate array, between the Z80-side decode and the VA/VD pad logic.

Parameters:
- SETUP_CYC, 1, MCLK cycles of address setup between BGACK assert and AS assert (legal range 1-3).
- TIMEOUT_CYC, 128, DTACK timeout in MCLK cycles; used only with the optional feature.

Ports:
- MCLK  in  1  master clock, all state on rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- z_mreq  in  1  Z80 memory request valid, active high, synchronous to MCLK.
- z_rd  in  1  Z80 read strobe, active high.
- z_wr  in  1  Z80 write strobe, active high.
- z_addr  in  16  Z80 address.
- z_wdata  in  8  Z80 write data.
- z_rdata  out  8  read data returned to the Z80.
- z_wait  out  1  Z80 WAIT request, active high.
- m_br  out  1  68000 bus request, active high.
- m_bg  in  1  68000 bus grant, active high.
- m_as_in  in  1  observed 68000 AS, active high.
- m_bgack  out  1  bus grant acknowledge, active high.
- m_dtack  in  1  DTACK, active high.
- va  out  23  VA[23:1] drive value.
- va_oe  out  1  enables VA, RW, AS and DS pads.
- m_as  out  1  address strobe, active high.
- m_uds  out  1  upper data strobe, active high.
- m_lds  out  1  lower data strobe, active high.
- m_rw  out  1  1 = read, 0 = write.
- vd_in  in  16  VD bus input.
- vd_out  out  16  VD drive value.
- vd_oe  out  1  VD output enable.

Behaviour:
- Reset (asynchronous, RESET_n = 0):
  - all outputs 0, except m_rw = 1;
  - bank = 0; FSM = IDLE.
  - Reset asserted mid-cycle aborts immediately and releases all bus lines the same instant.
- Access start: mreq_rise = z_mreq & ~z_mreq_q, where z_mreq_q is a registered copy. Each access starts only on mreq_rise; a held z_mreq never retriggers.
- Bank write:
  - Trigger: mreq_rise & z_wr & z_addr[15:8] == 8'h60.
  - Action: bank <= {z_wdata[0], bank[8:1]}.
  - No WAIT is raised and there is no bus activity.
- Window access: mreq_rise & z_addr[15] & (z_rd | z_wr).
  - va = {bank, z_addr[14:1]}, latched at start.
  - Byte lane: z_addr[0] = 0 selects UDS and VD[15:8]; z_addr[0] = 1 selects LDS and VD[7:0].
  - Write data: vd_out = {z_wdata, z_wdata}.
- Other addresses: ignored, z_wait stays 0.
- FSM states:
  - IDLE: on window start, z_wait = 1, m_br = 1 the next cycle -> REQ.
  - REQ: wait until m_bg & ~m_as_in. Then m_bgack = 1, va_oe = 1, m_rw = z_rd, vd_oe = z_wr; m_br = 0 the following cycle -> SETUP.
  - SETUP: count SETUP_CYC cycles -> STROBE, with m_as = 1 and the selected DS = 1.
  - STROBE: on m_dtack, latch z_rdata from the selected lane (reads only) -> END.
  - END: m_as = 0, DS = 0; one cycle -> REL.
  - REL: m_bgack = 0, va_oe = 0, vd_oe = 0, m_rw = 1, z_wait = 0 -> IDLE.
- Minimum latency: mreq_rise to z_wait falling = 5 + SETUP_CYC cycles, with BG and DTACK already asserted.
- Boundary conditions:
  - m_bg dropping while in REQ before the condition is met: stay in REQ, keep BR.
  - z_mreq dropping mid-access: the cycle completes; a write is always committed.
  - Bank write while the FSM is not IDLE: cannot occur, because the Z80 is stalled; it is ignored.
- z_rdata holds its value until the next read completes.

Optional Feature:
- Macro: Z80_BANK_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in STROBE.
  - At TIMEOUT_CYC cycles without DTACK: z_rdata = 8'hFF on reads, a write is dropped, and the FSM moves to END.
  - Counter clears on leaving STROBE.
- Undefined: STROBE waits indefinitely for DTACK; no counter is present.

Decomposition:
- Shared package fc_pkg holds:
  - FSM state enum (IDLE, REQ, SETUP, STROBE, END, REL);
  - BANK_W = 9;
  - BANK_REG_PAGE = 8'h60.
- One sub-module, z80_bank_reg: the serial 9-bit shifter plus the window address builder.
- The FSM stays in the top level.

Test Plan:
- Bank load: write 9 bytes with bit0 pattern 1,0,1,1,0,0,1,0,1 to 0x6000 -> bank = 9'h14D (register view; the last written bit lands in bank[8]); no m_br pulse.
- Window read: bank = 9'h14D, z_rd at 0x8001, m_bg held 1, DTACK 2 cycles after AS, vd_in = 16'hA55A -> va = {bank, 14'h0000}, m_lds = 1, m_uds = 0, z_rdata = 8'h5A, z_wait high for 8 cycles.
- Window write: z_wr 0xFFFE with data 8'h3C -> va = {bank, 14'h3FFF}, m_uds = 1, m_rw = 0, vd_out = 16'h3C3C, vd_oe high exactly while m_bgack is high.
- Grant delay: m_bg asserted 20 cycles late, then m_as_in held 1 for 5 more cycles -> m_bgack rises only on the first cycle with m_bg & ~m_as_in; m_br stays high until then.
- Mid-cycle reset: RESET_n low during STROBE -> m_as, m_bgack, va_oe and z_wait all 0 with no clock edge; the next access after reset proceeds normally.
- Timeout (Z80_BANK_TIMEOUT_EN): no DTACK on a read -> END after 128 STROBE cycles, z_rdata = 8'hFF, z_wait released.
